// File: rtl/int_sync_gateway.sv
// Interrupt gateway: per-source IDLE/PENDING/INFLIGHT tracking with level or counted-edge capture,
// fixed lowest-index arbitration onto a single claim/complete handshake to the interrupt controller.
module int_sync_gateway #(
  parameter int NUM_SRC    = 4,
  parameter int ID_W       = 2,
  parameter int EDGE_CNT_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [NUM_SRC-1:0] src_edge_mode,
  input  logic [NUM_SRC-1:0] src_enable,
  output logic               claim_valid,
  output logic [ID_W-1:0]    claim_id,
  input  logic               claim_ready,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PENDING  = 2'd1,
    S_INFLIGHT = 2'd2
  } state_e;

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

  state_e                state_q [NUM_SRC];
  state_e                state_d [NUM_SRC];
  logic [EDGE_CNT_W-1:0] cnt_q   [NUM_SRC];
  logic [EDGE_CNT_W-1:0] cnt_d   [NUM_SRC];
  logic [NUM_SRC-1:0]    prev_q;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] claim_hs;
  logic [NUM_SRC-1:0] done_hit;

  // prev_q resets low, so a line already high at reset release counts as one edge
  assign rise = src_edge_mode & src_in & ~prev_q;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pending[i] = (state_q[i] == S_PENDING);
    end
  end

  always_comb begin
    claim_valid = 1'b0;
    claim_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i] && src_enable[i]) begin
        claim_valid = 1'b1;
        claim_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    claim_hs = '0;
    done_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_hs[i] = claim_valid && claim_ready && (claim_id == ID_W'(i));
      done_hit[i] = complete_valid && (complete_id == ID_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];

      // a rise coinciding with a claim leaves the count unchanged, even when saturated
      if (rise[i] && !claim_hs[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!rise[i] && claim_hs[i] && src_edge_mode[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end

      case (state_q[i])
        S_IDLE: begin
          if (src_edge_mode[i] ? ((cnt_q[i] != '0) || rise[i]) : src_in[i]) begin
            state_d[i] = S_PENDING;
          end
        end
        S_PENDING: begin
          if (claim_hs[i]) begin
            state_d[i] = S_INFLIGHT;
          end
        end
        S_INFLIGHT: begin
          if (done_hit[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      prev_q <= src_in;
    end
  end

endmodule

// File: tb/tb_int_sync_gateway.sv
// Bench for int_sync_gateway: queue-free status model compared every cycle plus directed literal checks.
module tb_int_sync_gateway;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] src_in;
  logic [3:0] src_edge_mode;
  logic [3:0] src_enable;
  logic       claim_valid;
  logic [1:0] claim_id;
  logic       claim_ready;
  logic       complete_valid;
  logic [1:0] complete_id;
  logic [3:0] pending;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  int m_st   [4];   // 0 = waiting for a request, 1 = awaiting claim, 2 = being serviced
  int m_cnt  [4];   // edges owed to the consumer
  bit m_prev [4];

  int_sync_gateway #(.NUM_SRC(4), .ID_W(2), .EDGE_CNT_W(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .src_in        (src_in),
    .src_edge_mode (src_edge_mode),
    .src_enable    (src_enable),
    .claim_valid   (claim_valid),
    .claim_id      (claim_id),
    .claim_ready   (claim_ready),
    .complete_valid(complete_valid),
    .complete_id   (complete_id),
    .pending       (pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void exp_out(output bit v, output logic [1:0] id, output logic [3:0] p);
    v  = 1'b0;
    id = 2'd0;
    p  = 4'd0;
    for (int i = 0; i < 4; i++) p[i] = (m_st[i] == 1);
    for (int i = 3; i >= 0; i--) begin
      if (p[i] && src_enable[i]) begin
        v  = 1'b1;
        id = 2'(i);
      end
    end
  endfunction

  // model advance
  always @(posedge clock) begin
    bit         v, r, c;
    logic [1:0] id;
    logic [3:0] p;
    int         old;
    exp_out(v, id, p);
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        m_st[i]   = 0;
        m_cnt[i]  = 0;
        m_prev[i] = 1'b0;
      end else begin
        r   = src_edge_mode[i] && src_in[i] && !m_prev[i];
        c   = v && claim_ready && (id == 2'(i));
        old = m_cnt[i];
        if (src_edge_mode[i]) begin
          if (r && !c)                 m_cnt[i] = (old < 7) ? old + 1 : 7;
          else if (c && !r && old > 0) m_cnt[i] = old - 1;
        end
        case (m_st[i])
          0: if (src_edge_mode[i] ? (old > 0 || r) : src_in[i]) m_st[i] = 1;
          1: if (c) m_st[i] = 2;
          2: if (complete_valid && complete_id == 2'(i)) m_st[i] = 0;
          default: m_st[i] = 0;
        endcase
        m_prev[i] = src_in[i];
      end
    end
  end

  // every-cycle compare
  always @(negedge clock) begin
    bit         v;
    logic [1:0] id;
    logic [3:0] p;
    if (cmp_en) begin
      exp_out(v, id, p);
      chk("model_claim_valid", claim_valid, v);
      chk("model_claim_id", claim_id, id);
      chk("model_pending", pending, p);
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic claim();
    claim_ready = 1'b1;
    tick();
    claim_ready = 1'b0;
  endtask

  task automatic complete(input logic [1:0] id);
    complete_valid = 1'b1;
    complete_id    = id;
    tick();
    complete_valid = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      src_in[0] = 1'b1;
      tick();
      src_in[0] = 1'b0;
      tick();
    end
  endtask

  task automatic rounds(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      int w = 0;
      while (!(claim_valid && claim_id == 2'd0) && w < 4) begin
        tick();
        w++;
      end
      if (!(claim_valid && claim_id == 2'd0)) break;
      claim();
      complete(2'd0);
      n++;
    end
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b1;
    src_in         = 4'b0;
    src_edge_mode  = 4'b0;
    src_enable     = 4'hF;
    claim_ready    = 1'b0;
    complete_valid = 1'b0;
    complete_id    = 2'd0;
    repeat (3) tick();
    reset  = 1'b0;
    cmp_en = 1'b1;
    chk("reset_valid", claim_valid, 0);
    chk("reset_id", claim_id, 0);
    chk("reset_pending", pending, 0);

    // level source, one-cycle latency
    repeat (2) tick();
    src_in = 4'b0100;
    tick();
    chk("t1_valid", claim_valid, 1);
    chk("t1_id", claim_id, 2);
    chk("t1_pending", pending, 4'b0100);
    claim();
    chk("t1_after_claim_pending", pending, 0);
    chk("t1_after_claim_valid", claim_valid, 0);
    src_in = 4'b0;
    complete(2'd2);
    chk("t1_after_complete_valid", claim_valid, 0);

    // priority, then claim+complete on different sources in one cycle
    src_in = 4'b1010;
    tick();
    chk("t2_first_id", claim_id, 1);
    claim();
    chk("t2_second_valid", claim_valid, 1);
    chk("t2_second_id", claim_id, 3);
    chk("t2_second_pending", pending, 4'b1000);
    src_in         = 4'b0;
    claim_ready    = 1'b1;
    complete_valid = 1'b1;
    complete_id    = 2'd1;
    tick();
    claim_ready    = 1'b0;
    complete_valid = 1'b0;
    chk("t2_dual_pending", pending, 0);
    chk("t2_dual_valid", claim_valid, 0);
    complete(2'd3);

    // enable masks arbitration only
    src_in     = 4'b0001;
    src_enable = 4'b1110;
    tick();
    chk("en_masked_valid", claim_valid, 0);
    chk("en_masked_pending", pending, 4'b0001);
    src_enable = 4'hF;
    #1;
    chk("en_unmasked_valid", claim_valid, 1);
    chk("en_unmasked_id", claim_id, 0);
    src_in = 4'b0;
    claim();
    complete(2'd0);

    // edge counting
    src_edge_mode = 4'b0001;
    tick();
    pulses(3);
    rounds(n);
    chk("t3_edge_rounds", n, 3);

    // saturation at 7
    pulses(9);
    rounds(n);
    chk("t4_sat_rounds", n, 7);
    src_edge_mode = 4'b0;
    tick();

    // stray complete, level re-pend after one idle cycle
    complete(2'd3);
    chk("t5_stray_pending", pending, 0);
    chk("t5_stray_valid", claim_valid, 0);
    src_in = 4'b0010;
    tick();
    chk("t5_id", claim_id, 1);
    claim();
    complete(2'd1);
    chk("t5_idle_valid", claim_valid, 0);
    chk("t5_idle_pending", pending, 0);
    tick();
    chk("t5_repend_valid", claim_valid, 1);
    chk("t5_repend_id", claim_id, 1);
    chk("t5_repend_pending", pending, 4'b0010);
    src_in = 4'b0;
    claim();
    complete(2'd1);

    // reset mid-handshake
    src_in = 4'b0101;
    tick();
    chk("t6_first_id", claim_id, 0);
    claim();
    chk("t6_pre_valid", claim_valid, 1);
    chk("t6_pre_id", claim_id, 2);
    chk("t6_pre_pending", pending, 4'b0100);
    src_in = 4'b0;
    reset  = 1'b1;
    tick();
    chk("t6_rst_valid", claim_valid, 0);
    chk("t6_rst_id", claim_id, 0);
    chk("t6_rst_pending", pending, 0);
    reset = 1'b0;
    tick();
    chk("t6_post_valid", claim_valid, 0);
    chk("t6_post_pending", pending, 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
